vga_timing: RTL
===============

Name: vga_timing

Overview:
- Display-timing stage directly upstream of the pixel-colour generator. Produces the 640x480@60 Hz raster scan coordinates x/y that the colour generator consumes.
- Registers the colour generator's 8-bit rgb back in and drives the VGA connector: hsync, vsync and blanked R/G/B.
- Derives the 25 MHz pixel rate from the 50 MHz system clock with a clock enable; no second clock domain exists.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=2)
- SYNC_DELAY, 1, pixel ticks of delay applied to hsync/vsync/video_on to align with the registered rgb path (0..3)

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-low reset (0 = reset)
- rgb_in  input  8  pixel colour from the colour generator, {R[7:5],G[4:2],B[1:0]}
- x  output  11  current horizontal count, 0..H_TOTAL-1
- y  output  11  current vertical count, 0..V_TOTAL-1
- pixel_tick  output  1  one-clk pulse each pixel period
- video_on  output  1  undelayed: x<H_DISPLAY && y<V_DISPLAY
- frame_start  output  1  one-clk pulse as the counters wrap to (0,0)
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- vga_r  output  3  red to DAC
- vga_g  output  3  green to DAC
- vga_b  output  2  blue to DAC

Behaviour:
- H_TOTAL = sum of the four H params (800). V_TOTAL = sum of the four V params (525).
- Reset (reset==0 at a clk edge), all values after that edge:
  - divider=0, h=0, v=0
  - pixel_tick=0, frame_start=0
  - hsync=1, vsync=1
  - video_on reflects (0,0), i.e. 1
  - delay pipes filled with inactive values (sync=1, blank)
  - vga_r/g/b=0
- Reset wins over every other event. Reset asserted mid-frame restarts the raster at (0,0) on the next edge.
- Divider counts 0..CLK_DIV-1 and wraps. pixel_tick is registered and high for the one clk in which divider==CLK_DIV-1. After reset release, the first tick is in clk cycle CLK_DIV (1-based).
- On each clk where pixel_tick=1:
  - h<=h+1, or 0 when h==H_TOTAL-1.
  - On that h wrap only: v<=v+1, or 0 when v==V_TOTAL-1.
- x={h} and y={v}, zero-extended to 11 bits. Both are direct register outputs and hold stable for CLK_DIV clks. The downstream generator's one-clk registered lookup therefore completes within the pixel.
- frame_start=1 in the same clk as the pixel_tick where h==H_TOTAL-1 && v==V_TOTAL-1.
- Raw sync terms:
  - hs_raw low for H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vs_raw low for V_DISPLAY+V_FRONT <= v < V_DISPLAY+V_FRONT+V_SYNC (490..491).
- hs_raw, vs_raw and video_on pass through a SYNC_DELAY-deep shift register advanced only on pixel_tick. SYNC_DELAY=0 means no delay. The delayed outputs drive hsync, vsync and vid_d.
- On pixel_tick, the colour outputs update:
  - vid_d=1: {vga_r,vga_g,vga_b}<=rgb_in.
  - vid_d=0: all three forced to 0.
  - Colour outputs change only on pixel_tick.
- Counters never exceed TOTAL-1. No other wrap state exists.

Test Plan:
- Reset held 5 clks, released → x=0, y=0, hsync=1, vsync=1, rgb outs 0. pixel_tick first high in clk 2 after release; x=1 on the following clk.
- Free run 1600 clks (one line) → x returns to 0 and y=1. hsync low for exactly 96 ticks (192 clks), starting SYNC_DELAY ticks after x reaches 656.
- Free run one full frame → frame_start pulses once every 840000 clks, single-clk width. vsync low for exactly 2 lines (3200 clks), starting at y=490 plus delay. y never exceeds 524.
- rgb_in=8'hFF constant:
  - vga_r/g/b = 3'b111/3'b111/2'b11 for pixel x=0..639 of lines 0..479, offset by SYNC_DELAY.
  - 0 for x=640..799 and for lines 480..524.
- rgb_in=8'b11010000 at (x=10,y=20) → vga_r=3'b110, vga_g=3'b100, vga_b=2'b00 on the tick that displays that pixel.
- Reset pulsed for 1 clk at x=400, y=300 → next clk x=0, y=0, hsync=1, vsync=1. Sync/blank pipes are cleared, so no stale sync pulse appears.

Source files
------------

// File: rtl/vga_timing_if.sv
// Signal bundle between the raster timing stage, the colour generator and the VGA pins.
// master = timing stage (drives coordinates and DAC pins), slave = colour generator.
interface vga_timing_if;
  logic [7:0]  rgb_in;
  logic [10:0] x;
  logic [10:0] y;
  logic        pixel_tick;
  logic        video_on;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic [2:0]  vga_r;
  logic [2:0]  vga_g;
  logic [1:0]  vga_b;

  modport master (
    input  rgb_in,
    output x, y, pixel_tick, video_on, frame_start,
    output hsync, vsync, vga_r, vga_g, vga_b
  );

  modport slave (
    output rgb_in,
    input  x, y, pixel_tick, video_on, frame_start,
    input  hsync, vsync, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_timing.sv
// Raster timing for a VGA display: pixel-rate clock enable, h/v counters, sync generation
// and blanked, registered colour output. Single clock domain; pixel rate is a clock enable.
module vga_timing #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 1
) (
  input logic          clk,
  input logic          reset,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  logic             r_frame;
  logic [10:0]      r_h;
  logic [10:0]      r_v;
  logic [7:0]       r_rgb;

  logic w_hs_raw;
  logic w_vs_raw;
  logic w_video_on;
  logic w_hs_d;
  logic w_vs_d;
  logic w_vid_gate;

  assign w_hs_raw   = !((r_h >= HS_START) && (r_h < HS_END));
  assign w_vs_raw   = !((r_v >= VS_START) && (r_v < VS_END));
  assign w_video_on = (r_h < H_VIS) && (r_v < V_VIS);

  // Tick is raised one clock early so it coincides with divider == CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div   <= '0;
      r_tick  <= 1'b0;
      r_frame <= 1'b0;
      r_h     <= '0;
      r_v     <= '0;
      r_rgb   <= '0;
    end else begin
      r_div   <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_tick  <= (r_div == DIV_PRE);
      r_frame <= (r_div == DIV_PRE) && (r_h == H_LAST) && (r_v == V_LAST);
      if (r_tick) begin
        if (r_h == H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
        end
        r_rgb <= w_vid_gate ? vga.rgb_in : 8'h00;
      end
    end
  end

  // The colour register is gated by the blank bit entering the last pipe stage, so
  // colour, blank and sync all leave on the same tick.
  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign w_hs_d     = w_hs_raw;
      assign w_vs_d     = w_vs_raw;
      assign w_vid_gate = w_video_on;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] r_hs_pipe;
      logic [SYNC_DELAY-1:0] r_vs_pipe;
      logic [SYNC_DELAY-1:0] r_vid_pipe;

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_hs_pipe  <= '1;
          r_vs_pipe  <= '1;
          r_vid_pipe <= '0;
        end else if (r_tick) begin
          for (int i = SYNC_DELAY - 1; i > 0; i--) begin
            r_hs_pipe[i]  <= r_hs_pipe[i-1];
            r_vs_pipe[i]  <= r_vs_pipe[i-1];
            r_vid_pipe[i] <= r_vid_pipe[i-1];
          end
          r_hs_pipe[0]  <= w_hs_raw;
          r_vs_pipe[0]  <= w_vs_raw;
          r_vid_pipe[0] <= w_video_on;
        end
      end

      assign w_hs_d = r_hs_pipe[SYNC_DELAY-1];
      assign w_vs_d = r_vs_pipe[SYNC_DELAY-1];
      if (SYNC_DELAY == 1) begin : g_gate_raw
        assign w_vid_gate = w_video_on;
      end else begin : g_gate_pipe
        assign w_vid_gate = r_vid_pipe[SYNC_DELAY-2];
      end
    end
  endgenerate

  assign vga.x           = r_h;
  assign vga.y           = r_v;
  assign vga.pixel_tick  = r_tick;
  assign vga.frame_start = r_frame;
  assign vga.video_on    = w_video_on;
  assign vga.hsync       = w_hs_d;
  assign vga.vsync       = w_vs_d;
  assign vga.vga_r       = r_rgb[7:5];
  assign vga.vga_g       = r_rgb[4:2];
  assign vga.vga_b       = r_rgb[1:0];
endmodule
